// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes on the input and output sides.
// Single-cycle ops finish in one cycle. Shifts run one bit per cycle.
// MUL is a shift-add multiply, built only when SEQ_ALU_MUL_EN is defined.
// When the macro is not defined, op 1010 is handled as an illegal op.
module seq_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALUControl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Z,
    output logic             N,
    output logic             C,
    output logic             V
);

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpSlt  = 4'b0100;
    localparam logic [3:0] OpXor  = 4'b0101;
    localparam logic [3:0] OpSltu = 4'b0110;
    localparam logic [3:0] OpSll  = 4'b0111;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [3:0] OpMul  = 4'b1010;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d;
`endif

    logic             sub_mode;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic             ovf;
    logic [WIDTH-1:0] fast_res;
    logic             fast_c, fast_v;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic [WIDTH-1:0] step;
    logic             load_res;
    logic [WIDTH-1:0] res_val;
    logic             c_val, v_val;

    assign shamt    = B[SHW-1:0];
    assign is_shift = (ALUControl == OpSll) || (ALUControl == OpSrl) || (ALUControl == OpSra);

    // Single-cycle datapath on the live inputs; only sampled on the accept edge.
    always_comb begin
        // SUB, SLT and SLTU all use the adder in subtract mode.
        sub_mode = (ALUControl != OpAdd);
        b_eff    = sub_mode ? ~B : B;
        sum      = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_mode};
        ovf      = (sum[WIDTH-1] ^ A[WIDTH-1]) & ~(A[WIDTH-1] ^ B[WIDTH-1] ^ ALUControl[0]);
        fast_res = '0;
        fast_c   = 1'b0;
        fast_v   = 1'b0;
        case (ALUControl)
            OpAdd, OpSub: begin
                fast_res = sum[WIDTH-1:0];
                fast_c   = sum[WIDTH];
                fast_v   = ovf;
            end
            OpAnd:   fast_res = A & B;
            OpOr:    fast_res = A | B;
            OpXor:   fast_res = A ^ B;
            // SLT returns the sign bit of A-B.
            OpSlt:   fast_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
            OpSltu:  fast_res = {{(WIDTH-1){1'b0}}, ~sum[WIDTH]};
            default: fast_res = '0;
        endcase
    end

    // One iteration of the working register for the latched multi-cycle op.
    always_comb begin
        case (op_q)
            OpSll:   step = work_q << 1;
            OpSrl:   step = work_q >> 1;
`ifdef SEQ_ALU_MUL_EN
            OpMul:   step = work_q + (mplier_q[0] ? mcand_q : '0);
`endif
            default: step = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        endcase
    end

    // Next-state logic: FSM transitions, operand capture, and result/flag load.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        z_d      = z_q;
        n_d      = n_q;
        c_d      = c_q;
        v_d      = v_q;
`ifdef SEQ_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
`endif
        load_res = 1'b0;
        res_val  = '0;
        c_val    = 1'b0;
        v_val    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d = ALUControl;
                    if (is_shift) begin
                        if (shamt == '0) begin
                            state_d  = StDone;
                            load_res = 1'b1;
                            res_val  = A;
                        end else begin
                            state_d = StBusy;
                            work_d  = A;
                            cnt_d   = {1'b0, shamt};
                        end
                    end
`ifdef SEQ_ALU_MUL_EN
                    else if (ALUControl == OpMul) begin
                        state_d  = StBusy;
                        work_d   = '0;
                        mcand_d  = A;
                        mplier_d = B;
                        cnt_d    = (SHW+1)'(WIDTH);
                    end
`endif
                    else begin
                        state_d  = StDone;
                        load_res = 1'b1;
                        res_val  = fast_res;
                        c_val    = fast_c;
                        v_val    = fast_v;
                    end
                end
            end
            StBusy: begin
                work_d = step;
                cnt_d  = cnt_q - (SHW+1)'(1);
`ifdef SEQ_ALU_MUL_EN
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
`endif
                if (cnt_q == (SHW+1)'(1)) begin
                    state_d  = StDone;
                    load_res = 1'b1;
                    res_val  = step;
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (load_res) begin
            res_d = res_val;
            z_d   = (res_val == '0);
            n_d   = res_val[WIDTH-1];
            c_d   = c_val;
            v_d   = v_val;
        end
    end

    // State and datapath registers; reset drops any in-flight op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            op_q     <= '0;
            work_q   <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            z_q      <= 1'b0;
            n_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            z_q      <= z_d;
            n_q      <= n_d;
            c_q      <= c_d;
            v_q      <= v_d;
`ifdef SEQ_ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign Result    = res_q;
    assign Z         = z_q;
    assign N         = n_q;
    assign C         = c_q;
    assign V         = v_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu with WIDTH=32.
// The MUL expectations depend on whether SEQ_ALU_MUL_EN is defined.
module tb_seq_alu;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  ALUControl;
    logic [31:0] A;
    logic [31:0] B;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Result;
    logic        Z, N, C, V;

    int checks = 0;
    int errors = 0;

    seq_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALUControl (ALUControl),
        .A          (A),
        .B          (B),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Result     (Result),
        .Z          (Z),
        .N          (N),
        .C          (C),
        .V          (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issues one op and waits for out_valid; latency 1 means valid right after the accept edge.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic [3:0] flags,
                          output int lat, output int rdy_bad);
        in_valid   = 1'b1;
        ALUControl = op;
        A          = a;
        B          = b;
        @(posedge clk); #1;
        in_valid   = 1'b0;
        A          = $urandom;
        B          = $urandom;
        ALUControl = 4'($urandom_range(0, 15));
        lat     = 1;
        rdy_bad = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_bad++;
            @(posedge clk); #1;
            lat++;
        end
        res   = Result;
        flags = {Z, N, C, V};
    endtask

    task automatic pop(input string tag);
        chk({tag, "_done_rdy"}, 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_idle_ov"}, 64'(out_valid), 64'd0);
    endtask

    task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic [3:0] exp_flags, input int exp_lat);
        logic [31:0] res;
        logic [3:0]  flags;
        int          lat, rdy_bad;
        run_op(op, a, b, res, flags, lat, rdy_bad);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(res), 64'(exp_res));
        chk({tag, "_zncv"}, 64'(flags), 64'(exp_flags));
        chk({tag, "_busy_rdy"}, 64'(rdy_bad), 64'd0);
        pop(tag);
    endtask

    initial begin
        int bad;
        rst        = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        ALUControl = 4'd0;
        A          = '0;
        B          = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", 64'(Result), 64'd0);
        chk("rst_zncv", 64'({Z, N, C, V}), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rel_rdy", 64'(in_ready), 64'd1);
        chk("rel_ov", 64'(out_valid), 64'd0);

        // Flags are ordered {Z,N,C,V}.
        do_op("add_ovf",  4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0101, 1);
        do_op("add_cry",  4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1010, 1);
        do_op("sub_eq",   4'b0001, 32'd5,        32'd5,        32'h00000000, 4'b1010, 1);
        do_op("sub_brw",  4'b0001, 32'd3,        32'd5,        32'hFFFFFFFE, 4'b0100, 1);
        do_op("sub_ovf",  4'b0001, 32'h80000000, 32'd1,        32'h7FFFFFFF, 4'b0011, 1);
        do_op("slt",      4'b0100, 32'hFFFFFFFF, 32'd1,        32'h00000001, 4'b0000, 1);
        do_op("sltu",     4'b0110, 32'hFFFFFFFF, 32'd1,        32'h00000000, 4'b1000, 1);
        do_op("and",      4'b0010, 32'hF0F01234, 32'h0FF0FF00, 32'h00F01200, 4'b0000, 1);
        do_op("or",       4'b0011, 32'hF0F01234, 32'h0FF0FF00, 32'hFFF0FF34, 4'b0100, 1);
        do_op("xor",      4'b0101, 32'hF0F01234, 32'h0FF0FF00, 32'hFF00ED34, 4'b0100, 1);
        do_op("sll31",    4'b0111, 32'd1,        32'd31,       32'h80000000, 4'b0100, 32);
        do_op("sra4",     4'b1001, 32'h80000000, 32'd4,        32'hF8000000, 4'b0100, 5);
        do_op("srl4",     4'b1000, 32'h80000000, 32'd4,        32'h08000000, 4'b0000, 5);
        do_op("sll0",     4'b0111, 32'h00001234, 32'h00000020, 32'h00001234, 4'b0000, 1);
`ifdef SEQ_ALU_MUL_EN
        do_op("mul",      4'b1010, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 4'b0100, 33);
        do_op("mul_wrap", 4'b1010, 32'h80000001, 32'd3,        32'h80000003, 4'b0100, 33);
`else
        do_op("mul",      4'b1010, 32'h0000FFFF, 32'h0000FFFF, 32'h00000000, 4'b1000, 1);
`endif
        do_op("illegal",  4'b1111, 32'd5,        32'd5,        32'h00000000, 4'b1000, 1);

        // Backpressure: result holds while out_ready is low, even with a new op offered.
        in_valid = 1'b1; ALUControl = 4'b0000; A = 32'd3; B = 32'd4;
        @(posedge clk); #1;
        ALUControl = 4'b0000; A = 32'd10; B = 32'd20;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (Result !== 32'd7 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        chk("bp_res", 64'(Result), 64'd7);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_rel_rdy", 64'(in_ready), 64'd1);
        chk("bp_bubble", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_ov", 64'(out_valid), 64'd1);
        chk("bp_next_res", 64'(Result), 64'd30);
        pop("bp_next");

        // Reset in the middle of a multi-cycle op.
        in_valid = 1'b1;
`ifdef SEQ_ALU_MUL_EN
        ALUControl = 4'b1010; A = 32'h0000FFFF; B = 32'h0000FFFF;
`else
        ALUControl = 4'b0111; A = 32'd1; B = 32'd31;
`endif
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rbusy_res", 64'(Result), 64'd0);
        chk("rbusy_zncv", 64'({Z, N, C, V}), 64'd0);
        chk("rbusy_ov", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("rbusy_dropped", 64'(bad), 64'd0);

        // Reset while a result waits in DONE.
        in_valid = 1'b1; ALUControl = 4'b0001; A = 32'd5; B = 32'd5;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rdone_pre_zncv", 64'({Z, N, C, V}), 64'b1010);
        #3 rst = 1'b0;
        #1;
        chk("rdone_zncv", 64'({Z, N, C, V}), 64'd0);
        chk("rdone_ov", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rdone_rdy", 64'(in_ready), 64'd1);
        do_op("post_rst", 4'b0000, 32'd1, 32'd1, 32'd2, 4'b0000, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, multi-cycle successor to the single-cycle datapath ALU.
- Keeps the existing op encodings 000–100 (add/sub/and/or/slt) and their flag semantics.
- Adds xor, sltu, iterative shifts and an optional iterative multiply, behind a valid/ready handshake on both sides.
- Sits between the decode/register-read stage and writeback in the multi-cycle core; the core stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are 8..64.
- SHW, $clog2(WIDTH), shift-amount width taken from B (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-low reset.
- in_valid  input  1  op/A/B valid.
- in_ready  output  1  block can accept a new op.
- ALUControl  input  4  op code, see Behaviour.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B (shift amount = B[SHW-1:0]).
- out_valid  output  1  Result/flags valid.
- out_ready  input  1  consumer takes the result.
- Result  output  WIDTH  registered result.
- Z  output  1  zero flag.
- N  output  1  negative flag.
- C  output  1  carry flag.
- V  output  1  overflow flag.

Behaviour:
- Op codes:
  - 0000 ADD, 0001 SUB (A+~B+1), 0010 AND, 0011 OR.
  - 0100 SLT (signed, {0..,sign of A-B}), 0101 XOR, 0110 SLTU (unsigned, = ~carry of A-B).
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1010 MUL (low WIDTH bits of A*B, unsigned).
  - All other codes are illegal.
- FSM states IDLE, BUSY, DONE. Reset state is IDLE.
  - in_ready = 1 only in IDLE.
  - out_valid = 1 only in DONE.
- Accept: in_valid & in_ready at a clock edge. ALUControl, A and B are latched; the inputs are don't-care afterwards.
- Single-cycle ops (ADD, SUB, AND, OR, SLT, XOR, SLTU, illegal):
  - IDLE goes to DONE on the accept edge.
  - out_valid is high the cycle after accept (latency 1).
- Shifts: IDLE goes to BUSY with count = B[SHW-1:0].
  - Each BUSY cycle shifts the working register by one bit and decrements count.
  - BUSY goes to DONE on the edge where count reaches 0.
  - Latency is k+1 cycles for shift amount k.
  - Shift by 0 takes no BUSY cycle: latency 1, Result = A.
  - SRA fills with A[WIDTH-1].
- MUL: shift-add over exactly WIDTH BUSY cycles, so latency is WIDTH+1.
  - Partial product is accumulated modulo 2^WIDTH; upper bits are discarded.
- DONE: Result and flags are held stable while out_ready = 0. out_valid & out_ready at an edge moves DONE to IDLE.
  - No new op is accepted in the same cycle (one bubble per op).
- Flags are computed from the final Result and registered with it:
  - Z = (Result == 0).
  - N = Result[WIDTH-1].
  - C = carry-out of the adder, ADD/SUB only; otherwise 0. For SUB, C=1 means no borrow.
  - V = signed overflow, ADD/SUB only: (sum MSB ^ A MSB) & ~(A MSB ^ B MSB ^ op[0]); otherwise 0.
- Illegal op: Result = 0, Z = 1, N = C = V = 0, latency 1.
- Reset values, applied at any time including mid-BUSY or mid-DONE:
  - FSM = IDLE, Result = 0, Z = N = C = V = 0.
  - out_valid = 0, in_ready = 1 after reset release.
  - Any in-flight op is dropped and no result is produced.
- Outputs are registered only; there are no combinational paths from inputs to outputs except none (in_ready depends only on state).

Optional Feature:
- Macro: SEQ_ALU_MUL_EN.
- Defined: op 1010 performs the iterative MUL described above, WIDTH+1 cycle latency.
- Undefined: the multiplier datapath and its counter use are omitted. Op 1010 is illegal: Result = 0, Z = 1, latency 1.

Test Plan:
- WIDTH=32, ADD A=0x7FFFFFFF B=0x00000001 -> Result=0x80000000, N=1, V=1, C=0, Z=0. out_valid exactly 1 cycle after accept.
- SUB A=5 B=5 -> Result=0, Z=1, C=1, V=0. Then SLT A=0xFFFFFFFF B=1 -> Result=1. Then SLTU with the same operands -> Result=0.
- SLL A=1 B=31 -> Result=0x80000000 after 32 cycles, in_ready=0 throughout BUSY. Then SRA A=0x80000000 B=4 -> 0xF8000000 after 5 cycles. Shift with B=0 -> Result=A at latency 1.
- With SEQ_ALU_MUL_EN: MUL A=0x0000FFFF B=0x0000FFFF -> 0xFFFE0001 after 33 cycles, C=V=0. Without the macro: same op -> Result=0, Z=1 at latency 1.
- Backpressure: hold out_ready=0 for 5 cycles after ADD 3+4 -> Result=7 stable, out_valid=1, in_ready=0. On release, in_ready=1 on the next cycle, then accept a new op.
- Deassert rst mid-MUL (cycle 10) and mid-DONE -> all outputs 0, out_valid=0 immediately (async). After release, in_ready=1 and a subsequent ADD 1+1 returns 2 correctly.
